// File: rtl/bus_arbiter_pkg.sv
// Purpose: shared encodings and widths for the two-master bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_arbiter_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned SEL_W           = 2;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Purpose: grant wait counter; tc flags the last cycle allowed before a bus error.
// Latency: count updates one cycle after enable; tc is combinational from the count.
// Backpressure: none; saturates at LIMIT-1 instead of wrapping.
module bus_timeout_counter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // Count waiting grant cycles; cleared outside a grant, holds at the terminal value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // Count k means this is grant cycle k+1, so LIMIT-1 marks the LIMIT-th cycle.
  assign tc = (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Purpose: arbitrates two masters onto one slave bus with ack/err handshakes and a grant timeout.
// Latency: request at T drives s_ds at T+1; s_ack at K drives mN_ack from K+1.
// Backpressure: masters hold ds until ack/err; slave stalls by withholding s_ack up to TIMEOUT_CYCLES.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned ROUND_ROBIN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_ds,
  input  logic              m1_ds,
  input  logic              m0_rw,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [DATA_W-1:0] m0_write,
  input  logic [DATA_W-1:0] m1_write,
  output logic [DATA_W-1:0] m0_read,
  output logic [DATA_W-1:0] m1_read,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic              m0_err,
  output logic              m1_err,
  output logic              s_ds,
  output logic              s_rw,
  output logic [ADDR_W-1:0] s_addr,
  output logic [SEL_W-1:0]  s_sel,
  output logic [DATA_W-1:0] s_write,
  input  logic [DATA_W-1:0] s_read,
  input  logic              s_ack
);

  state_t            state;
  logic              last_q;   // last granted master; also the owner during GRANT/DONE
  logic [DATA_W-1:0] rd_q;
  logic              pick;
  logic              in_grant;
  logic              tmo_tc;
  logic              owner_ds;

  assign in_grant = (state == GRANT0) || (state == GRANT1);
  assign owner_ds = last_q ? m1_ds : m0_ds;

  bus_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (!in_grant),
    .enable(in_grant && !s_ack),
    .tc    (tmo_tc)
  );

  // Choose which requester to grant from IDLE; only meaningful when a ds is high.
  always_comb begin
    pick = 1'b0;
    if (m0_ds && m1_ds) begin
      pick = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
    end else begin
      pick = m1_ds;
    end
  end

  // Arbitration FSM with registered slave-side and master-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last_q  <= 1'b1;
      rd_q    <= '0;
      s_ds    <= 1'b0;
      s_rw    <= 1'b0;
      s_addr  <= '0;
      s_sel   <= '0;
      s_write <= '0;
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_ds || m1_ds) begin
            last_q  <= pick;
            s_ds    <= 1'b1;
            s_rw    <= pick ? m1_rw    : m0_rw;
            s_addr  <= pick ? m1_addr  : m0_addr;
            s_sel   <= pick ? m1_sel   : m0_sel;
            s_write <= pick ? m1_write : m0_write;
            state   <= pick ? GRANT1 : GRANT0;
          end
        end
        GRANT0, GRANT1: begin
          // A master dropping ds here is ignored; the slave cycle always completes.
          if (s_ack) begin
            rd_q  <= s_read;
            s_ds  <= 1'b0;
            state <= DONE;
            if (last_q) m1_ack <= 1'b1;
            else        m0_ack <= 1'b1;
          end else if (tmo_tc) begin
            s_ds  <= 1'b0;
            state <= DONE;
            if (last_q) m1_err <= 1'b1;
            else        m0_err <= 1'b1;
          end
        end
        DONE: begin
          if (!owner_ds) begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is exposed only to the master currently holding ack.
  assign m0_read = m0_ack ? rd_q : '0;
  assign m1_read = m1_ack ? rd_q : '0;

endmodule
